// File: rtl/llsc_reservation_monitor_if.sv
// Bus bundle between the MEM-stage decode/flush logic and the LL/SC reservation monitor.
// The master side issues LL/SC/store/flush; the slave (monitor) returns SC results and LL bits.
interface llsc_reservation_monitor_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] flush;
  logic              ll_we;
  logic [CH_W-1:0]   ll_ch;
  logic [ADDR_W-1:0] ll_addr;
  logic              sc_req;
  logic [CH_W-1:0]   sc_ch;
  logic [ADDR_W-1:0] sc_addr;
  logic              st_valid;
  logic [CH_W-1:0]   st_ch;
  logic [ADDR_W-1:0] st_addr;
  logic              sc_done;
  logic              sc_ok;
  logic [NUM_CH-1:0] llbit_o;

  modport master (
    output flush, ll_we, ll_ch, ll_addr, sc_req, sc_ch, sc_addr, st_valid, st_ch, st_addr,
    input  sc_done, sc_ok, llbit_o
  );

  modport slave (
    input  flush, ll_we, ll_ch, ll_addr, sc_req, sc_ch, sc_addr, st_valid, st_ch, st_addr,
    output sc_done, sc_ok, llbit_o
  );
endinterface

// File: rtl/llsc_reservation_monitor.sv
// Per-channel LL/SC reservation tracker: one granule reservation per channel, invalidated by
// cross-channel store snoops, flushes, SC consumption and an optional expiry timer.
module llsc_reservation_monitor #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GRAN_LSB = 2,
  parameter int unsigned TIMEOUT  = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  llsc_reservation_monitor_if.slave bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned G_W  = ADDR_W - GRAN_LSB;

  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [G_W-1:0]    gran_q [NUM_CH];
  logic [G_W-1:0]    gran_d [NUM_CH];
  logic              sc_done_q, sc_ok_q, sc_ok_d;

  logic [NUM_CH-1:0] ll_set, sc_hit, st_hit, expire;
  logic [G_W-1:0]    ll_gran, sc_gran, st_gran;
  logic              st_in_range;

  assign ll_gran     = bus.ll_addr[ADDR_W-1:GRAN_LSB];
  assign sc_gran     = bus.sc_addr[ADDR_W-1:GRAN_LSB];
  assign st_gran     = bus.st_addr[ADDR_W-1:GRAN_LSB];
  assign st_in_range = 32'(bus.st_ch) < NUM_CH;

  if (GRAN_LSB > 0) begin : g_lsb_sink
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.ll_addr[GRAN_LSB-1:0], bus.sc_addr[GRAN_LSB-1:0],
                           bus.st_addr[GRAN_LSB-1:0]};
  end

  // Out-of-range channel indices never equal any c, so they decode to no channel.
  always_comb begin
    ll_set = '0;
    sc_hit = '0;
    st_hit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ll_set[c] = bus.ll_we && (bus.ll_ch == CH_W'(c));
      sc_hit[c] = bus.sc_req && (bus.sc_ch == CH_W'(c));
      st_hit[c] = bus.st_valid && st_in_range && (bus.st_ch != CH_W'(c)) &&
                  (gran_q[c] == st_gran);
    end
  end

  // SC is judged on start-of-cycle state, so a same-cycle snoop or LL cannot affect it.
  always_comb begin
    sc_ok_d = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sc_hit[c] && valid_q[c] && (gran_q[c] == sc_gran) && !bus.flush[c]) begin
        sc_ok_d = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      gran_d[c] = gran_q[c];
      if (bus.flush[c]) begin
        valid_d[c] = 1'b0;
      end else if (ll_set[c]) begin
        valid_d[c] = 1'b1;
        gran_d[c]  = ll_gran;
      end else if (sc_hit[c] || st_hit[c] || expire[c]) begin
        valid_d[c] = 1'b0;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_timer
    localparam int unsigned T_W   = $clog2(TIMEOUT + 1);
    localparam logic [T_W-1:0] TMax  = T_W'(TIMEOUT);
    localparam logic [T_W-1:0] TLast = T_W'(TIMEOUT - 1);

    logic [T_W-1:0] timer_q [NUM_CH];
    logic [T_W-1:0] timer_d [NUM_CH];

    always_comb begin
      expire = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        timer_d[c] = timer_q[c];
        expire[c]  = valid_q[c] && (timer_q[c] == TLast);
        if (ll_set[c]) begin
          timer_d[c] = '0;
        end else if (valid_q[c] && (timer_q[c] != TMax)) begin
          timer_d[c] = timer_q[c] + T_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          timer_q[c] <= '0;
        end
      end else begin
        timer_q <= timer_d;
      end
    end
  end else begin : g_no_timer
    assign expire = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      sc_done_q <= 1'b0;
      sc_ok_q   <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        gran_q[c] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      gran_q    <= gran_d;
      sc_done_q <= bus.sc_req;
      sc_ok_q   <= sc_ok_d;
    end
  end

  assign bus.sc_done = sc_done_q;
  assign bus.sc_ok   = sc_ok_q;
  assign bus.llbit_o = valid_q;

endmodule

// File: doc/llsc_reservation_monitor.md
Name: llsc_reservation_monitor

Overview:
- Multi-channel successor to the single LLbit register, for LL/SC atomics.
- Holds one reservation per hardware channel: valid bit, tracked granule address and an optional expiry timer.
- Stores from other channels snoop and invalidate matching reservations; SC checks are answered with a registered, one-cycle-latency result.
- Sits beside the MEM stage; fed by LL/SC/store decode and the exception flush unit.

Parameters:
- NUM_CH, 2, number of channels (hardware threads/cores); 1..8.
- ADDR_W, 32, physical address width.
- GRAN_LSB, 2, address bits below this are ignored for matching (4-byte granule); 0..ADDR_W-1.
- TIMEOUT, 0, cycles a reservation lives before auto-expiry; 0 disables expiry.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  NUM_CH  per-channel exception/ERET flush; clears that channel's reservation.
- ll_we  in  1  LL commit: set reservation.
- ll_ch  in  $clog2(NUM_CH) (min 1)  channel issuing the LL.
- ll_addr  in  ADDR_W  LL physical address.
- sc_req  in  1  SC check request.
- sc_ch  in  $clog2(NUM_CH) (min 1)  channel issuing the SC.
- sc_addr  in  ADDR_W  SC physical address.
- st_valid  in  1  committed store (ordinary store or successful SC) for snooping.
- st_ch  in  $clog2(NUM_CH) (min 1)  channel issuing the store.
- st_addr  in  ADDR_W  store physical address.
- sc_done  out  1  pulses one cycle after sc_req.
- sc_ok  out  1  SC success; valid while sc_done=1, 0 otherwise.
- llbit_o  out  NUM_CH  per-channel reservation valid bits (registered).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All valid bits, stored addresses, timers, sc_done and sc_ok go to 0.
  - The block acts on the first clk edge after rst_n deasserts.
- Match rule: addr[ADDR_W-1:GRAN_LSB] equal to the stored granule. Only granule bits are stored.
- SC check (sc_req=1):
  - Evaluated against state registered at the start of the cycle.
  - ok = valid[sc_ch] AND match(sc_addr, addr[sc_ch]) AND NOT flush[sc_ch].
  - Next edge: sc_done=1, sc_ok=ok.
  - The channel's reservation is cleared on that same edge, whether or not the SC succeeded.
  - Back-to-back sc_req produces back-to-back sc_done pulses. sc_done/sc_ok return to 0 the cycle after the last request.
- LL (ll_we=1) on the next edge:
  - valid[ll_ch]=1, addr[ll_ch]=ll_addr granule, timer[ll_ch]=0.
  - A new LL overwrites any existing reservation on that channel.
- Snoop (st_valid=1):
  - Clears valid[c] for every c != st_ch whose stored granule matches st_addr.
  - The storing channel's own reservation is unaffected.
- Timer (TIMEOUT>0):
  - Width $clog2(TIMEOUT+1). Increments each cycle while valid, saturating.
  - When the timer equals TIMEOUT-1 with valid set, valid clears on the next edge; the reservation lives exactly TIMEOUT cycles after the LL edge.
  - With TIMEOUT=0, no timer logic and no expiry.
- Per-channel next-state priority, highest first:
  1. flush → clear.
  2. LL on this channel → set (overrides the SC clear, the snoop and the expiry in the same cycle).
  3. SC on this channel → clear.
  4. Snoop match or expiry → clear.
  5. Otherwise hold.
- Simultaneous cases:
  - SC on A and store from B to the same granule in one cycle: the SC is ordered first, so sc_ok=1 if A held the reservation, and A's reservation is then cleared.
  - LL and SC on the same channel in one cycle: SC result uses the old state; the LL's new reservation survives.
  - flush[sc_ch] with sc_req in the same cycle: sc_ok=0, reservation cleared.
- Out-of-range channel indices (>= NUM_CH) are ignored; sc_done still pulses, with sc_ok=0.
- No X on outputs after reset; llbit_o is a direct register output.

Test Plan:
1. Reset then basic: NUM_CH=2. rst_n low mid-sequence with a reservation set → llbit_o=00 immediately, without waiting for a clock edge. Then LL ch0 @0x1000, SC ch0 @0x1000 → sc_done=1, sc_ok=1 one cycle later; llbit_o[0]=0 afterwards.
2. Granule match: LL ch1 @0x2000, SC ch1 @0x2003 → sc_ok=1 (GRAN_LSB=2). Repeat with SC @0x2004 → sc_ok=0; reservation cleared in both cases.
3. Snoop: LL ch0 @0x3000, store ch1 @0x3002 → llbit_o[0]=0, later SC ch0 sc_ok=0. Store ch0 @0x3000 after a fresh LL ch0 → llbit_o[0] stays 1.
4. Flush priority: LL ch1 set; same cycle flush[1]=1 and sc_req ch1 → sc_ok=0, llbit_o[1]=0. Flush coinciding with ll_we on ch1 → llbit_o[1]=0.
5. Simultaneous: LL ch0 @0x40 and store ch1 @0x40 in one cycle → llbit_o[0]=1. SC ch0 @0x40 with store ch1 @0x40 in one cycle → sc_ok=1.
6. Timeout: TIMEOUT=4, LL ch0 at edge N → llbit_o[0]=1 through edge N+3, 0 at edge N+4; SC at N+5 → sc_ok=0. New LL at N+2 restarts the count.
